// File: rtl/bilinear_3x_sched.sv
// Window/phase scheduler for the 3x bilinear upscaler: raster walk, 3x3 phase issue, credit throttle.
// Optional BILI_SCHED_STALL_CNT_EN adds a saturating stall counter output.
module bilinear_3x_sched #(
  parameter int ROW_CNT_WIDTH = 12,
  parameter int COL_CNT_WIDTH = 12,
  parameter int CREDITS       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [COL_CNT_WIDTH-1:0] src_w_i,
  input  logic [ROW_CNT_WIDTH-1:0] src_h_i,
  output logic                     win_req_o,
  output logic [ROW_CNT_WIDTH-1:0] win_row_o,
  output logic [COL_CNT_WIDTH-1:0] win_col_o,
  input  logic                     win_valid_i,
  output logic                     row_clamp_o,
  output logic                     col_clamp_o,
  output logic                     calc_en_o,
  output logic [1:0]               phase_y_o,
  output logic [1:0]               phase_x_o,
  output logic [ROW_CNT_WIDTH+1:0] tgt_row_o,
  output logic [COL_CNT_WIDTH+1:0] tgt_col_o,
  input  logic                     credit_ret_i,
  output logic                     busy_o,
`ifdef BILI_SCHED_STALL_CNT_EN
  output logic [31:0]              stall_cnt_o,
`endif
  output logic                     frame_done_o
);

  // state | meaning
  // IDLE  | waiting for start
  // REQ   | window requested, waiting for win_valid
  // ISSUE | issuing the nine phases of the current window
  // DRAIN | all issued, waiting for every credit to return
  // DONE  | one-cycle frame_done
  typedef enum logic [2:0] {IDLE, REQ, ISSUE, DRAIN, DONE} state_t;

  localparam logic [3:0]               CRED_MAX = 4'(CREDITS);
  localparam logic [ROW_CNT_WIDTH-1:0] ROW_ONE  = ROW_CNT_WIDTH'(1);
  localparam logic [COL_CNT_WIDTH-1:0] COL_ONE  = COL_CNT_WIDTH'(1);

  state_t                   state_q;
  logic [ROW_CNT_WIDTH-1:0] h_q, win_row_q;
  logic [COL_CNT_WIDTH-1:0] w_q, win_col_q;
  logic [1:0]               py_q, px_q;
  logic                     last_q;
  logic [3:0]               credits_q;
  logic                     win_req_q, row_clamp_q, col_clamp_q, calc_en_q, busy_q, frame_done_q;
  logic [1:0]               phase_y_q, phase_x_q;
  logic [ROW_CNT_WIDTH+1:0] tgt_row_q;
  logic [COL_CNT_WIDTH+1:0] tgt_col_q;

  logic                     slot_d, issue_d, col_last_d, row_last_d;
  logic [3:0]               credits_d;
  logic [1:0]               nxt_py_d, nxt_px_d;
  logic [ROW_CNT_WIDTH+1:0] tgt_row_d;
  logic [COL_CNT_WIDTH+1:0] tgt_col_d;
  logic [ROW_CNT_WIDTH-1:0] nxt_row_d;
  logic [COL_CNT_WIDTH-1:0] nxt_col_d;

  always_comb begin
    // py_q/px_q always hold the next phase to issue; they are zero while in REQ
    slot_d    = ((state_q == REQ) && win_valid_i) || ((state_q == ISSUE) && !last_q);
    issue_d   = slot_d && (credits_q != 4'd0);
    credits_d = credits_q;
    if (issue_d && !credit_ret_i)
      credits_d = credits_q - 4'd1;
    else if (!issue_d && credit_ret_i && (credits_q != CRED_MAX))
      credits_d = credits_q + 4'd1;
    nxt_px_d   = (px_q == 2'd2) ? 2'd0 : px_q + 2'd1;
    nxt_py_d   = (px_q == 2'd2) ? py_q + 2'd1 : py_q;
    tgt_row_d  = ({2'b00, win_row_q} << 1) + {2'b00, win_row_q} + {{ROW_CNT_WIDTH{1'b0}}, py_q};
    tgt_col_d  = ({2'b00, win_col_q} << 1) + {2'b00, win_col_q} + {{COL_CNT_WIDTH{1'b0}}, px_q};
    col_last_d = (win_col_q == w_q - COL_ONE);
    row_last_d = (win_row_q == h_q - ROW_ONE);
    nxt_col_d  = col_last_d ? '0 : win_col_q + COL_ONE;
    nxt_row_d  = col_last_d ? win_row_q + ROW_ONE : win_row_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      h_q          <= '0;
      w_q          <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      py_q         <= 2'd0;
      px_q         <= 2'd0;
      last_q       <= 1'b0;
      credits_q    <= CRED_MAX;
      win_req_q    <= 1'b0;
      row_clamp_q  <= 1'b0;
      col_clamp_q  <= 1'b0;
      calc_en_q    <= 1'b0;
      phase_y_q    <= 2'd0;
      phase_x_q    <= 2'd0;
      tgt_row_q    <= '0;
      tgt_col_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      frame_done_q <= 1'b0;
      calc_en_q    <= issue_d;
      // a stalled slot still presents the pending phase, so it holds visibly
      if (slot_d) begin
        phase_y_q <= py_q;
        phase_x_q <= px_q;
        tgt_row_q <= tgt_row_d;
        tgt_col_q <= tgt_col_d;
        if (issue_d) begin
          py_q   <= nxt_py_d;
          px_q   <= nxt_px_d;
          last_q <= (py_q == 2'd2) && (px_q == 2'd2);
        end
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if ((src_w_i != '0) && (src_h_i != '0)) begin
              w_q         <= src_w_i;
              h_q         <= src_h_i;
              win_row_q   <= '0;
              win_col_q   <= '0;
              py_q        <= 2'd0;
              px_q        <= 2'd0;
              last_q      <= 1'b0;
              row_clamp_q <= (src_h_i == ROW_ONE);
              col_clamp_q <= (src_w_i == COL_ONE);
              win_req_q   <= 1'b1;
              state_q     <= REQ;
            end else begin
              frame_done_q <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        REQ: begin
          if (win_valid_i) begin
            win_req_q <= 1'b0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (last_q) begin
            win_col_q <= nxt_col_d;
            win_row_q <= nxt_row_d;
            py_q      <= 2'd0;
            px_q      <= 2'd0;
            last_q    <= 1'b0;
            if (col_last_d && row_last_d) begin
              row_clamp_q <= 1'b0;
              col_clamp_q <= 1'b0;
              state_q     <= DRAIN;
            end else begin
              row_clamp_q <= (nxt_row_d == h_q - ROW_ONE);
              col_clamp_q <= (nxt_col_d == w_q - COL_ONE);
              win_req_q   <= 1'b1;
              state_q     <= REQ;
            end
          end
        end
        DRAIN: begin
          if (credits_q == CRED_MAX) begin
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BILI_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= 32'd0;
    else if ((state_q == IDLE) && start_i)
      stall_cnt_q <= 32'd0;
    else if ((((state_q == ISSUE) && !last_q && (credits_q == 4'd0)) ||
              ((state_q == REQ) && !win_valid_i)) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign win_req_o    = win_req_q;
  assign win_row_o    = win_row_q;
  assign win_col_o    = win_col_q;
  assign row_clamp_o  = row_clamp_q;
  assign col_clamp_o  = col_clamp_q;
  assign calc_en_o    = calc_en_q;
  assign phase_y_o    = phase_y_q;
  assign phase_x_o    = phase_x_q;
  assign tgt_row_o    = tgt_row_q;
  assign tgt_col_o    = tgt_col_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_bilinear_3x_sched.sv
// Self-checking bench for bilinear_3x_sched: directed frames plus randomized frames against a
// raster/phase reference list and a credit-balance model.
module tb_bilinear_3x_sched;
  localparam int RW   = 12;
  localparam int CW   = 12;
  localparam int CR   = 4;
  localparam int LOGN = 2048;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] src_w = '0;
  logic [RW-1:0] src_h = '0;
  logic          win_valid = 1'b0;
  logic          credit_ret = 1'b0;
  logic          win_req, row_clamp, col_clamp, calc_en, busy, frame_done;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic [1:0]    phase_y, phase_x;
  logic [RW+1:0] tgt_row;
  logic [CW+1:0] tgt_col;
`ifdef BILI_SCHED_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  bilinear_3x_sched #(.ROW_CNT_WIDTH(RW), .COL_CNT_WIDTH(CW), .CREDITS(CR)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .src_w_i(src_w), .src_h_i(src_h),
    .win_req_o(win_req), .win_row_o(win_row), .win_col_o(win_col), .win_valid_i(win_valid),
    .row_clamp_o(row_clamp), .col_clamp_o(col_clamp), .calc_en_o(calc_en),
    .phase_y_o(phase_y), .phase_x_o(phase_x), .tgt_row_o(tgt_row), .tgt_col_o(tgt_col),
    .credit_ret_i(credit_ret), .busy_o(busy),
`ifdef BILI_SCHED_STALL_CNT_EN
    .stall_cnt_o(stall_cnt),
`endif
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc, lat, wv_wait, wv_max, cred_m, n_issue, n_done;
  bit auto_ret, ret_prev;
  int ret_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] win_q[$];
  bit ce_log[LOGN];
  bit req_log[LOGN];
  bit busy_log[LOGN];
  bit fd_log[LOGN];
  logic [1:0] py_log[LOGN];
  logic [1:0] px_log[LOGN];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {2'b00, win_req, win_row, win_col, row_clamp, col_clamp, calc_en,
            phase_y, phase_x, tgt_row, tgt_col, busy, frame_done};
  endfunction

  // Reference: every window in raster order, nine phases each, target = 3*index + phase.
  task automatic build_model(input int w, input int h);
    exp_q.delete();
    win_q.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        win_q.push_back({40'd0, RW'(r), CW'(c)});
        for (int py = 0; py < 3; py++)
          for (int px = 0; px < 3; px++)
            exp_q.push_back({30'd0, 14'(3*r + py), 14'(3*c + px), 2'(py), 2'(px),
                             (r == h - 1), (c == w - 1)});
      end
  endtask

  task automatic step();
    credit_ret = 1'b0;
    if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
      credit_ret = 1'b1;
      ret_q.delete(0);
    end
    win_valid = 1'b0;
    if (win_req) begin
      if (wv_wait == 0) begin
        win_valid = 1'b1;
        chk("win_count", 64'(win_q.size() > 0), 64'd1);
        if (win_q.size() > 0) chk("win_pos", {40'd0, win_row, win_col}, win_q.pop_front());
        wv_wait = int'($urandom_range(wv_max, 0));
      end else begin
        wv_wait--;
      end
    end
    ret_prev = credit_ret;
    @(posedge clk);
    #1;
    cyc++;
    cred_m = cred_m + int'(ret_prev) - int'(calc_en);
    if (cred_m > CR) cred_m = CR;
    if (calc_en) begin
      n_issue++;
      chk("credit_floor", 64'(cred_m >= 0), 64'd1);
      chk("issue_count", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0)
        chk("issue", {30'd0, tgt_row, tgt_col, phase_y, phase_x, row_clamp, col_clamp},
            exp_q.pop_front());
      if (auto_ret) ret_q.push_back(cyc + lat);
    end
    if (frame_done) n_done++;
    if (cyc < LOGN) begin
      ce_log[cyc]   = calc_en;
      req_log[cyc]  = win_req;
      busy_log[cyc] = busy;
      fd_log[cyc]   = frame_done;
      py_log[cyc]   = phase_y;
      px_log[cyc]   = phase_x;
    end
  endtask

  task automatic begin_frame(input int w, input int h);
    src_w = CW'(w);
    src_h = RW'(h);
    build_model(w, h);
    cyc = 0;
    n_issue = 0;
    n_done = 0;
    wv_wait = int'($urandom_range(wv_max, 0));
    for (int i = 0; i < LOGN; i++) begin
      ce_log[i] = 1'b0; req_log[i] = 1'b0; busy_log[i] = 1'b0; fd_log[i] = 1'b0;
      py_log[i] = 2'd0; px_log[i] = 2'd0;
    end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int w, input int h);
    while (n_done == 0 && cyc < LOGN - 8) step();
    chk({tag, "_done_seen"}, 64'(n_done), 64'd1);
    chk({tag, "_returns_before_done"}, 64'(ret_q.size()), 64'd0);
    repeat (3) step();
    chk({tag, "_done_once"}, 64'(n_done), 64'd1);
    chk({tag, "_issue_total"}, 64'(n_issue), 64'(9 * w * h));
    chk({tag, "_model_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_credits_home"}, 64'(cred_m), 64'(CR));
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cnt, fd, last_ce;
    cred_m = CR;
    auto_ret = 1'b1;
    lat = 3;
    wv_max = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", out_vec(), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_outputs", out_vec(), 64'd0);

    // A: 2x2 frame, immediate win_valid, credits looped back after 3 cycles
    begin_frame(2, 2);
    finish_frame("A", 2, 2);
    chk("A_req_c1", 64'(req_log[1]), 64'd1);
    chk("A_busy_c1", 64'(busy_log[1]), 64'd1);
    chk("A_ce_c1", 64'(ce_log[1]), 64'd0);
    chk("A_ce_c2", 64'(ce_log[2]), 64'd1);

    // credit returns while already full must be ignored
    credit_ret = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    credit_ret = 1'b0;

    // B: 3 wide x 1 high, no returns until cycle 20, then a same-cycle return/issue at one credit
    auto_ret = 1'b0;
    ret_q.delete();
    ret_q.push_back(20);
    ret_q.push_back(30);
    ret_q.push_back(31);
    begin_frame(3, 1);
    while (cyc < 34) step();
    cnt = 0;
    for (int i = 1; i < 20; i++) cnt += int'(ce_log[i]);
    chk("B_issues_before_return", 64'(cnt), 64'd4);
    chk("B_ce_c5", 64'(ce_log[5]), 64'd1);
    chk("B_ce_c6", 64'(ce_log[6]), 64'd0);
    chk("B_phase_held", {60'd0, py_log[15], px_log[15]}, 64'h5);
    chk("B_ce_c21", 64'(ce_log[21]), 64'd0);
    chk("B_ce_c22", 64'(ce_log[22]), 64'd1);
    chk("B_phase_c22", {60'd0, py_log[22], px_log[22]}, 64'h5);
    chk("B_ce_c23", 64'(ce_log[23]), 64'd0);
    chk("B_ce_c31", 64'(ce_log[31]), 64'd0);
    chk("B_ce_c32", 64'(ce_log[32]), 64'd1);
    chk("B_ce_c33", 64'(ce_log[33]), 64'd1);
    chk("B_ce_c34", 64'(ce_log[34]), 64'd0);
    for (int i = 35; i < 39; i++) ret_q.push_back(i);
    auto_ret = 1'b1;
    lat = 3;
    finish_frame("B", 3, 1);

    // C: zero width frame
    begin_frame(0, 5);
    finish_frame("C", 0, 5);
    chk("C_busy_c1", 64'(busy_log[1]), 64'd1);
    chk("C_done_c1", 64'(fd_log[1]), 64'd1);
    chk("C_req_c1", 64'(req_log[1]), 64'd0);
    chk("C_busy_c2", 64'(busy_log[2]), 64'd0);
    chk("C_done_c2", 64'(fd_log[2]), 64'd0);

    // D: asynchronous reset in the middle of a 4x4 frame, then a clean frame
    wv_max = 2;
    lat = 4;
    begin_frame(4, 4);
    while (n_issue < 5 && cyc < 500) step();
    chk("D_reached_issue", 64'(n_issue >= 5), 64'd1);
    #2;
    rst_n = 1'b0;
    credit_ret = 1'b0;
    win_valid = 1'b0;
    #1;
    chk("D_async_reset", out_vec(), 64'd0);
    fd = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      fd += int'(frame_done) + int'(busy);
    end
    chk("D_quiet_in_reset", 64'(fd), 64'd0);
    rst_n = 1'b1;
    ret_q.delete();
    cred_m = CR;
    @(posedge clk);
    #1;
    begin_frame(4, 4);
    finish_frame("D", 4, 4);

    // E: randomized frames
    for (int k = 0; k < 4; k++) begin
      int w, h;
      w = int'($urandom_range(4, 1));
      h = int'($urandom_range(3, 1));
      wv_max = int'($urandom_range(3, 0));
      lat = int'($urandom_range(7, 3));
      begin_frame(w, h);
      finish_frame("E", w, h);
    end

`ifdef BILI_SCHED_STALL_CNT_EN
    // S: first window's win_valid held off for 5 REQ cycles; issue-side stalls read from the trace
    wv_max = 0;
    lat = 3;
    begin_frame(1, 1);
    wv_wait = 5;
    finish_frame("S", 1, 1);
    last_ce = 0;
    for (int i = 0; i < LOGN; i++) if (ce_log[i]) last_ce = i;
    chk("S_stall_cnt", 64'(stall_cnt), 64'(5 + (last_ce - 6 - 9)));
`else
    last_ce = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
